// File: rtl/stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_pkg : pixel beat record and streamer state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package stream_pkg;

  localparam int PIX_DATA_BITS  = 8;
  localparam int PIX_COORD_BITS = 4;

  typedef struct packed {
    logic [PIX_DATA_BITS-1:0]  data;
    logic [PIX_COORD_BITS-1:0] x;
    logic [PIX_COORD_BITS-1:0] y;
    logic                      eol;
    logic                      eof;
  } pixel_beat_t;

  localparam int BEAT_BITS = $bits(pixel_beat_t);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } streamer_state_t;

endpackage
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skid_fifo2 : two-entry valid/ready buffer of pixel beats, async reset
// Rev 1.0
// ---------------------------------------------------------------------------
module skid_fifo2
  import stream_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [BEAT_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [BEAT_BITS-1:0] rd_data,
  output logic [1:0]           count
);

  logic [BEAT_BITS-1:0] entry_q [2];
  logic [BEAT_BITS-1:0] entry_d [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 pop;
  logic                 push;

  always_comb begin
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pop        = rd_en && (count_q != 2'd0);
    // A full buffer still accepts a write when the head leaves this cycle.
    push       = wr_en && ((count_q != 2'd2) || pop);

    if (push) begin
      entry_d[wr_ptr_q] = wr_data;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = entry_q[rd_ptr_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/raster_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// raster_streamer : reads a frame from sync-read memory as a raster beat stream
// Rev 1.0
// ---------------------------------------------------------------------------
module raster_streamer
  import stream_pkg::*;
#(
  parameter int DATA_BITS  = PIX_DATA_BITS,
  parameter int COORD_BITS = PIX_COORD_BITS,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COORD_BITS-1:0] r_row_length,
  input  logic [COORD_BITS-1:0] r_num_rows,
  input  logic [ADDR_BITS-1:0]  r_base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_BITS-1:0]  mem_addr,
  input  logic [DATA_BITS-1:0]  mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  done
);

  streamer_state_t       state_q, state_d;
  logic [COORD_BITS-1:0] row_len_q, row_len_d;
  logic [COORD_BITS-1:0] num_rows_q, num_rows_d;
  logic [COORD_BITS-1:0] x_q, x_d;
  logic [COORD_BITS-1:0] y_q, y_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  pixel_beat_t           meta_q, meta_d;

  logic                  issue;
  logic                  pop;
  logic                  last_x;
  logic                  last_y;
  logic [2:0]            pending;
  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [BEAT_BITS-1:0]  fifo_head_bits;
  pixel_beat_t           fifo_head;
  pixel_beat_t           fifo_wr;

  assign fifo_head = pixel_beat_t'(fifo_head_bits);
  assign pop       = fifo_valid && out_ready;
  assign pending   = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign last_x    = (x_q == (row_len_q - 1'b1));
  assign last_y    = (y_q == (num_rows_q - 1'b1));
  // A beat leaving this cycle frees its slot, so the buffer plus the
  // in-flight read never exceeds two entries yet streams one pixel per cycle.
  assign issue     = (state_q == FETCH) && (pending < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    meta_d     = meta_q;
    inflight_d = issue;

    case (state_q)
      IDLE: begin
        if (start) begin
          row_len_d  = r_row_length;
          num_rows_d = r_num_rows;
          addr_d     = r_base_addr;
          x_d        = '0;
          y_d        = '0;
          state_d    = ((r_row_length == '0) || (r_num_rows == '0)) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          meta_d.data = '0;
          meta_d.x    = x_q;
          meta_d.y    = y_q;
          meta_d.eol  = last_x;
          meta_d.eof  = last_x && last_y;
          // Raster order makes base + y*row_length + x a plain increment.
          addr_d      = addr_q + 1'b1;
          if (last_x) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (last_y) begin
              state_d = DRAIN;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_head.eof) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      meta_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      meta_q     <= meta_d;
    end
  end

  always_comb begin
    fifo_wr      = meta_q;
    fifo_wr.data = mem_rd_data;
  end

  skid_fifo2 u_skid (
    .clk      (clk),
    .rst      (reset),
    .wr_en    (inflight_q),
    .wr_data  (fifo_wr),
    .rd_en    (out_ready),
    .rd_valid (fifo_valid),
    .rd_data  (fifo_head_bits),
    .count    (fifo_count)
  );

  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_head.data;
  assign out_x     = fifo_head.x;
  assign out_y     = fifo_head.y;
  assign out_eol   = fifo_head.eol;
  assign out_eof   = fifo_head.eof;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_raster_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_raster_streamer : frame-level scoreboard bench for raster_streamer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_raster_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] r_row_length = '0;
  logic [3:0] r_num_rows = '0;
  logic [7:0] r_base_addr = '0;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic       out_eol;
  logic       out_eof;
  logic       busy;
  logic       done;

  raster_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .r_row_length (r_row_length),
    .r_num_rows   (r_num_rows),
    .r_base_addr  (r_base_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_eol      (out_eol),
    .out_eof      (out_eof),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  typedef struct {
    logic [7:0] d;
    logic [3:0] x;
    logic [3:0] y;
    logic       eol;
    logic       eof;
  } beat_t;

  typedef struct {
    int rl;
    int nr;
    int base;
    int pct;
    int inject;
    int exp_beats;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int issued, xfers, first_valid, eof_cyc, done_cyc, done_cnt, busy_cnt, max_out;
  bit stall_prev;
  beat_t prev_beat;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    issued = 0; xfers = 0; first_valid = -1; eof_cyc = -1; done_cyc = -1;
    done_cnt = 0; busy_cnt = 0; max_out = 0; stall_prev = 1'b0;
  endtask

  task automatic monitor();
    beat_t e;
    int outstanding;
    if (!mon_en || reset) return;
    if (busy) busy_cnt++;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_beat.d);
      chk("stall_xy", {out_x, out_y}, {prev_beat.x, prev_beat.y});
    end
    if (mem_rd_en) issued++;
    if (out_valid && out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_x", out_x, e.x);
        chk("beat_y", out_y, e.y);
        chk("beat_eol", out_eol, e.eol);
        chk("beat_eof", out_eof, e.eof);
      end
      if (out_eof) eof_cyc = cyc;
    end
    outstanding = issued - xfers;
    if (outstanding > max_out) max_out = outstanding;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    stall_prev = out_valid && !out_ready;
    prev_beat.d = out_data;
    prev_beat.x = out_x;
    prev_beat.y = out_y;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_ready(input int pct);
    out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
  endtask

  task automatic build_model(input int rl, input int nr, input int base);
    beat_t b;
    exp_q.delete();
    for (int y = 0; y < nr; y++) begin
      for (int x = 0; x < rl; x++) begin
        b.d   = mem[(base + y * rl + x) % 256];
        b.x   = x[3:0];
        b.y   = y[3:0];
        b.eol = (x == rl - 1);
        b.eof = (x == rl - 1) && (y == nr - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    int n;
    build_model(v.rl, v.nr, v.base);
    clear_mon();
    mon_en = 1'b1;
    r_row_length = v.rl[3:0];
    r_num_rows   = v.nr[3:0];
    r_base_addr  = v.base[7:0];
    start        = 1'b1;
    set_ready(v.pct);
    n = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      if (k == v.inject) begin
        start        = 1'b1;
        r_row_length = 4'd3;
        r_num_rows   = 4'd2;
        r_base_addr  = 8'h40;
      end else begin
        start = 1'b0;
      end
      set_ready(v.pct);
      step();
    end
    start = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("beat_count", xfers, v.exp_beats);
    chk("model_drained", exp_q.size(), 0);
    chk("first_valid_latency", first_valid - n, 3);
    chk("done_after_eof", done_cyc - eof_cyc, 1);
    chk("max_pending_le2", (max_out <= 2) ? 1 : 0, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      if (a < 144)
        mem[a] = ((a / 12) < 6) ? (((a % 12) < 6) ? 8'h00 : 8'hAA)
                                : (((a % 12) < 6) ? 8'h55 : 8'hFF);
      else
        mem[a] = 8'($urandom);
    end

    vecs[0] = '{rl: 12, nr: 12, base: 8'h00, pct: 100, inject: -1, exp_beats: 144};
    vecs[1] = '{rl: 12, nr: 12, base: 8'h00, pct: 50,  inject: -1, exp_beats: 144};
    vecs[2] = '{rl: 12, nr: 12, base: 8'h00, pct: 100, inject: 20, exp_beats: 144};
    vecs[3] = '{rl: 5,  nr: 3,  base: 8'hF8, pct: 70,  inject: -1, exp_beats: 15};
    vecs[4] = '{rl: 15, nr: 15, base: 8'h20, pct: 80,  inject: 40, exp_beats: 225};
    vecs[5] = '{rl: 1,  nr: 1,  base: 8'h07, pct: 100, inject: -1, exp_beats: 1};

    clear_mon();
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      step();
    end

    // Degenerate frames: zero row length, then zero row count.
    for (int z = 0; z < 2; z++) begin
      exp_q.delete();
      clear_mon();
      mon_en       = 1'b1;
      r_row_length = (z == 0) ? 4'd0 : 4'd6;
      r_num_rows   = (z == 0) ? 4'd5 : 4'd0;
      start        = 1'b1;
      out_ready    = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk("zero_no_valid", (first_valid < 0) ? 1 : 0, 1);
      chk("zero_no_reads", issued, 0);
      chk("zero_busy_seen", (busy_cnt >= 1) ? 1 : 0, 1);
      chk("zero_done_pulses", done_cnt, 1);
      chk("zero_idle_after", busy, 0);
    end

    // Reset mid-frame with the buffer full and downstream stalled.
    mon_en       = 1'b0;
    r_row_length = 4'd12;
    r_num_rows   = 4'd12;
    r_base_addr  = 8'h00;
    out_ready    = 1'b0;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_rd_en", mem_rd_en, 0);
    step();
    step();
    reset = 1'b0;
    step();
    run_frame(vecs[0]);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
